// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the fetch/LSQ front ends, the arbiter and the memory port.
// slave: the arbiter's view. master: the surrounding environment's view.
interface mem_bus_arbiter_if #(
    parameter int XLEN     = 32,
    parameter int NUM_TAGS = 16
);
    localparam int CNT_W = $clog2(NUM_TAGS) + 1;

    // instruction-fetch requester
    logic [1:0]      ic_command;
    logic [XLEN-1:0] ic_addr;
    logic            ic_squash;
    logic [3:0]      ic_response;
    logic [63:0]     ic_data;
    logic [3:0]      ic_tag;

    // load/store requester
    logic [1:0]      dc_command;
    logic [XLEN-1:0] dc_addr;
    logic [63:0]     dc_wdata;
    logic [3:0]      dc_response;
    logic [63:0]     dc_data;
    logic [3:0]      dc_tag;

    // unified memory port
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;

    // status
    logic [CNT_W-1:0] outstanding;
    logic             stray_tag;

    modport slave (
        input  ic_command, ic_addr, ic_squash,
        input  dc_command, dc_addr, dc_wdata,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output ic_response, ic_data, ic_tag,
        output dc_response, dc_data, dc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output outstanding, stray_tag
    );

    modport master (
        output ic_command, ic_addr, ic_squash,
        output dc_command, dc_addr, dc_wdata,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  ic_response, ic_data, ic_tag,
        input  dc_response, dc_data, dc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  outstanding, stray_tag
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between IC and DC, tracks which requester
// owns each accepted load tag, and steers tagged returns back to that owner.
module mem_bus_arbiter #(
    parameter int XLEN         = 32,
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);
    localparam int CNT_W    = $clog2(NUM_TAGS) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int TAG_W    = 4;
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    logic                 ic_active;
    logic                 dc_active;
    logic                 grant_ic;
    logic                 grant_dc;
    logic                 accept_load;
    logic [STARVE_W-1:0]  starve_cnt_reg;

    logic [NUM_TAGS-1:0]  valid_reg;
    logic [NUM_TAGS-1:0]  owner_dc_reg;
    logic [NUM_TAGS-1:0]  dropped_reg;
    logic [NUM_TAGS-1:0]  valid_next;
    logic [NUM_TAGS-1:0]  owner_dc_next;
    logic [NUM_TAGS-1:0]  dropped_next;
    logic [NUM_TAGS-1:0]  alloc_vec;
    logic [NUM_TAGS-1:0]  ret_hit_vec;

    logic                 ret_valid;
    logic                 ret_dropped;
    logic                 ret_owner_dc;
    logic                 route_ic;
    logic                 route_dc;
    logic [CNT_W-1:0]     valid_count;
    logic [CNT_W-1:0]     outstanding_reg;

    // Requests are ignored while reset is high so nothing reaches memory.
    // A STORE from IC is not a legal request and is treated as idle.
    assign ic_active = !reset && (bus.ic_command == CMD_LOAD);
    assign dc_active = !reset && ((bus.dc_command == CMD_LOAD) || (bus.dc_command == CMD_STORE));

    // DC wins ties unless IC has been passed over STARVE_LIMIT times in a row.
    assign grant_ic = ic_active && (!dc_active || (starve_cnt_reg >= STARVE_W'(STARVE_LIMIT)));
    assign grant_dc = dc_active && !grant_ic;

    // Only loads that memory actually accepted occupy a tag entry.
    assign accept_load = (grant_ic || (grant_dc && (bus.dc_command == CMD_LOAD)))
                         && (bus.mem2proc_response != '0);

    // Drive the grantee's request onto the memory port.
    always_comb begin
        bus.proc2mem_command = CMD_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (grant_ic) begin
            bus.proc2mem_command = CMD_LOAD;
            bus.proc2mem_addr    = bus.ic_addr;
        end else if (grant_dc) begin
            bus.proc2mem_command = bus.dc_command;
            bus.proc2mem_addr    = bus.dc_addr;
            bus.proc2mem_data    = bus.dc_wdata;
        end
    end

    assign bus.ic_response = grant_ic ? bus.mem2proc_response : '0;
    assign bus.dc_response = grant_dc ? bus.mem2proc_response : '0;

    // Per-entry next state. Entry 0 is the "no tag" code and never holds state.
    // Allocation is applied last so a same-cycle return and re-accept of one
    // tag leaves the new owner in place.
    generate
        for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_entry
            if (gi == 0) begin : g_null
                assign alloc_vec[gi]     = 1'b0;
                assign ret_hit_vec[gi]   = 1'b0;
                assign valid_next[gi]    = 1'b0;
                assign owner_dc_next[gi] = 1'b0;
                assign dropped_next[gi]  = 1'b0;
            end else begin : g_live
                assign alloc_vec[gi]     = accept_load && (bus.mem2proc_response == TAG_W'(gi));
                assign ret_hit_vec[gi]   = valid_reg[gi] && (bus.mem2proc_tag == TAG_W'(gi));
                assign valid_next[gi]    = alloc_vec[gi] || (valid_reg[gi] && !ret_hit_vec[gi]);
                assign owner_dc_next[gi] = alloc_vec[gi] ? grant_dc : owner_dc_reg[gi];
                assign dropped_next[gi]  = alloc_vec[gi]
                                         ? (grant_ic && bus.ic_squash)
                                         : (dropped_reg[gi] ||
                                            (bus.ic_squash && valid_reg[gi] && !owner_dc_reg[gi]));
            end
        end
    endgenerate

    // Return lookup: at most one entry can match the returning tag.
    assign ret_valid    = !reset && (|ret_hit_vec);
    assign ret_dropped  = |(ret_hit_vec & dropped_reg);
    assign ret_owner_dc = |(ret_hit_vec & owner_dc_reg);
    assign route_ic     = ret_valid && !ret_dropped && !ret_owner_dc;
    assign route_dc     = ret_valid && !ret_dropped && ret_owner_dc;

    assign bus.ic_tag    = route_ic ? bus.mem2proc_tag  : '0;
    assign bus.ic_data   = route_ic ? bus.mem2proc_data : '0;
    assign bus.dc_tag    = route_dc ? bus.mem2proc_tag  : '0;
    assign bus.dc_data   = route_dc ? bus.mem2proc_data : '0;
    assign bus.stray_tag = !reset && (bus.mem2proc_tag != '0) && !(|ret_hit_vec);

    // Count entries that will be valid after this edge.
    always_comb begin
        valid_count = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            valid_count = valid_count + CNT_W'(valid_next[i]);
        end
    end

    // Tag table and occupancy register.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg       <= '0;
            owner_dc_reg    <= '0;
            dropped_reg     <= '0;
            outstanding_reg <= '0;
        end else begin
            valid_reg       <= valid_next;
            owner_dc_reg    <= owner_dc_next;
            dropped_reg     <= dropped_next;
            outstanding_reg <= valid_count;
        end
    end

    assign bus.outstanding = outstanding_reg;

    // Count consecutive cycles in which IC asked but DC was chosen instead.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else if (ic_active && !grant_ic) begin
            if (starve_cnt_reg != STARVE_W'(STARVE_LIMIT)) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end else begin
            starve_cnt_reg <= '0;
        end
    end
endmodule
